// File: rtl/config_sequencer.sv
// ---------------------------------------------------------------------------
// config_sequencer
//
// Streams a serial configuration bitstream from a host into three FPGA
// configuration chains in the fixed order CLB -> CB -> SB. Each chain has
// its own shift strobe and serial data output. A chain whose tile count is
// zero is skipped entirely.
//
// Optional feature (macro CFG_PARITY_EN): after each tile's last data bit
// one extra even-parity bit is accepted without strobing any chain. A
// mismatch sets a sticky error flag. The load still runs to completion.
// With the macro undefined there is no parity state and error is tied low.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   start       one-cycle request to begin a load (honoured in IDLE/DONE)
//   cfg_bit     serial configuration bit from the host
//   cfg_valid   cfg_bit is valid this cycle
//   cfg_ready   sequencer accepts cfg_bit this cycle
//   prgm_b      0 while a load is in progress, 1 when idle or configured
//   CLB_prgm_b  CLB chain shift strobe;  bit_in_CLB  CLB chain serial data
//   cb_prgm_b   CB chain shift strobe;   bit_in_CB   CB chain serial data
//   sb_prgm_b   SB chain shift strobe;   bit_in_SB   SB chain serial data
//   done        full load completed
//   error       sticky parity error
// ---------------------------------------------------------------------------
module config_sequencer #(
    parameter int CLB_BITS  = 296,
    parameter int CLB_TILES = 1,
    parameter int CB_BITS   = 48,
    parameter int CB_TILES  = 4,
    parameter int SB_BITS   = 768,
    parameter int SB_TILES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic cfg_bit,
    input  logic cfg_valid,
    output logic cfg_ready,
    output logic prgm_b,
    output logic CLB_prgm_b,
    output logic bit_in_CLB,
    output logic cb_prgm_b,
    output logic bit_in_CB,
    output logic sb_prgm_b,
    output logic bit_in_SB,
    output logic done,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_CLB = 3'd1,
        LOAD_CB  = 3'd2,
        LOAD_SB  = 3'd3,
`ifdef CFG_PARITY_EN
        PARITY   = 3'd4,
`endif
        DONE     = 3'd5
    } state_t;

    // Next load phase after 'cur' has finished (IDLE means "nothing loaded
    // yet"), skipping every phase that has no tiles.
    function automatic state_t next_phase(input state_t cur);
        state_t nxt;
        nxt = DONE;
        if (cur == IDLE && CLB_TILES != 0)
            nxt = LOAD_CLB;
        else if ((cur == IDLE || cur == LOAD_CLB) && CB_TILES != 0)
            nxt = LOAD_CB;
        else if (cur != LOAD_SB && SB_TILES != 0)
            nxt = LOAD_SB;
        return nxt;
    endfunction

    state_t      state_q, state_d;
    state_t      phase_q, phase_d;     // load phase to resume after PARITY
    logic [9:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  tile_cnt_q, tile_cnt_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        prgm_b_q, prgm_b_d;
    logic        done_q, done_d;
    logic        clb_stb_q, clb_stb_d, clb_bit_q, clb_bit_d;
    logic        cb_stb_q, cb_stb_d, cb_bit_q, cb_bit_d;
    logic        sb_stb_q, sb_stb_d, sb_bit_q, sb_bit_d;
`ifdef CFG_PARITY_EN
    logic        parity_q, parity_d;   // running XOR of the current tile's data
    logic        error_q, error_d;
`endif

    logic        accept;
    logic        tile_end;
    logic [9:0]  last_bit;
    logic [2:0]  last_tile;

    assign accept = cfg_valid && cfg_ready_q;

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        tile_cnt_d = tile_cnt_q;
        done_d     = done_q;
        clb_stb_d  = 1'b0;
        cb_stb_d   = 1'b0;
        sb_stb_d   = 1'b0;
        clb_bit_d  = clb_bit_q;
        cb_bit_d   = cb_bit_q;
        sb_bit_d   = sb_bit_q;
`ifdef CFG_PARITY_EN
        parity_d   = parity_q;
        error_d    = error_q;
`endif
        tile_end   = 1'b0;
        last_bit   = '0;
        last_tile  = '0;

        case (phase_q)
            LOAD_CLB: begin last_bit = 10'(CLB_BITS - 1); last_tile = 3'(CLB_TILES - 1); end
            LOAD_CB:  begin last_bit = 10'(CB_BITS - 1);  last_tile = 3'(CB_TILES - 1);  end
            LOAD_SB:  begin last_bit = 10'(SB_BITS - 1);  last_tile = 3'(SB_TILES - 1);  end
            default:  ;
        endcase

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = next_phase(IDLE);
                    phase_d    = state_d;
                    bit_cnt_d  = '0;
                    tile_cnt_d = '0;
                    done_d     = (state_d == DONE);
`ifdef CFG_PARITY_EN
                    parity_d   = 1'b0;
                    error_d    = 1'b0;
`endif
                end
            end
            LOAD_CLB, LOAD_CB, LOAD_SB: begin
                if (accept) begin
                    if (state_q == LOAD_CLB) begin
                        clb_stb_d = 1'b1;
                        clb_bit_d = cfg_bit;
                    end else if (state_q == LOAD_CB) begin
                        cb_stb_d  = 1'b1;
                        cb_bit_d  = cfg_bit;
                    end else begin
                        sb_stb_d  = 1'b1;
                        sb_bit_d  = cfg_bit;
                    end
`ifdef CFG_PARITY_EN
                    parity_d = parity_q ^ cfg_bit;
`endif
                    if (bit_cnt_q == last_bit) begin
                        bit_cnt_d = '0;
`ifdef CFG_PARITY_EN
                        state_d   = PARITY;
`else
                        tile_end  = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 10'd1;
                    end
                end
            end
`ifdef CFG_PARITY_EN
            PARITY: begin
                // Host sends the even-parity bit: it must equal the XOR of
                // the tile's data bits.
                if (accept) begin
                    if (cfg_bit != parity_q)
                        error_d = 1'b1;
                    parity_d = 1'b0;
                    tile_end = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Tile boundary: move to the next tile, or to the next non-empty
        // phase once the last tile of this phase is complete.
        if (tile_end) begin
            if (tile_cnt_q == last_tile) begin
                state_d    = next_phase(phase_q);
                phase_d    = state_d;
                tile_cnt_d = '0;
                done_d     = (state_d == DONE);
            end else begin
                state_d    = phase_q;
                tile_cnt_d = tile_cnt_q + 3'd1;
            end
        end

        cfg_ready_d = (state_d == LOAD_CLB) || (state_d == LOAD_CB) ||
`ifdef CFG_PARITY_EN
                      (state_d == PARITY) ||
`endif
                      (state_d == LOAD_SB);
        prgm_b_d    = !cfg_ready_d;
    end

    // NOTE: non-blocking assignments for all state so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= IDLE;
            bit_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            cfg_ready_q <= 1'b0;
            prgm_b_q    <= 1'b1;
            done_q      <= 1'b0;
            clb_stb_q   <= 1'b0;
            clb_bit_q   <= 1'b0;
            cb_stb_q    <= 1'b0;
            cb_bit_q    <= 1'b0;
            sb_stb_q    <= 1'b0;
            sb_bit_q    <= 1'b0;
`ifdef CFG_PARITY_EN
            parity_q    <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            prgm_b_q    <= prgm_b_d;
            done_q      <= done_d;
            clb_stb_q   <= clb_stb_d;
            clb_bit_q   <= clb_bit_d;
            cb_stb_q    <= cb_stb_d;
            cb_bit_q    <= cb_bit_d;
            sb_stb_q    <= sb_stb_d;
            sb_bit_q    <= sb_bit_d;
`ifdef CFG_PARITY_EN
            parity_q    <= parity_d;
            error_q     <= error_d;
`endif
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign prgm_b     = prgm_b_q;
    assign done       = done_q;
    assign CLB_prgm_b = clb_stb_q;
    assign bit_in_CLB = clb_bit_q;
    assign cb_prgm_b  = cb_stb_q;
    assign bit_in_CB  = cb_bit_q;
    assign sb_prgm_b  = sb_stb_q;
    assign bit_in_SB  = sb_bit_q;
`ifdef CFG_PARITY_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_config_sequencer
//
// Bench for config_sequencer. A default-parameter instance is compared on
// every cycle against a model that tracks only the number of accepted bits
// since start and maps that index onto (chain, tile, bit) arithmetically.
// A second, tiny instance (no CLB, one 4-bit CB, one 4-bit SB) is checked
// against hand-written expectations. Build with +define+CFG_PARITY_EN to
// exercise the parity variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_config_sequencer;

    localparam int CLB_B = 296, CLB_T = 1;
    localparam int CB_B  = 48,  CB_T  = 4;
    localparam int SB_B  = 768, SB_T  = 4;
`ifdef CFG_PARITY_EN
    localparam int PB        = 1;
    localparam int TOTAL_ACC = 3569;
    localparam int BAD_IDX   = 443;   // parity slot of CB tile 2
    localparam int S_N       = 10;
    localparam logic [9:0] S_SEQ = 10'b0011011101;  // 1,0,1,1,P1,0,1,1,0,P0
`else
    localparam int PB        = 0;
    localparam int TOTAL_ACC = 3560;
    localparam int BAD_IDX   = -1;
    localparam int S_N       = 8;
    localparam logic [9:0] S_SEQ = 10'b0001101101;  // 1,0,1,1,0,1,1,0
`endif
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, cfg_bit, cfg_valid;
    logic cfg_ready, prgm_b, CLB_prgm_b, bit_in_CLB, cb_prgm_b, bit_in_CB;
    logic sb_prgm_b, bit_in_SB, done, error;

    logic s_start, s_bit, s_valid;
    logic s_ready, s_prgm_b, s_clb_s, s_clb_b, s_cb_s, s_cb_b, s_sb_s, s_sb_b, s_done, s_error;

    config_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .prgm_b(prgm_b), .CLB_prgm_b(CLB_prgm_b), .bit_in_CLB(bit_in_CLB),
        .cb_prgm_b(cb_prgm_b), .bit_in_CB(bit_in_CB), .sb_prgm_b(sb_prgm_b), .bit_in_SB(bit_in_SB),
        .done(done), .error(error)
    );

    config_sequencer #(
        .CLB_TILES(0), .CB_TILES(1), .CB_BITS(4), .SB_TILES(1), .SB_BITS(4)
    ) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .cfg_bit(s_bit), .cfg_valid(s_valid),
        .cfg_ready(s_ready), .prgm_b(s_prgm_b), .CLB_prgm_b(s_clb_s), .bit_in_CLB(s_clb_b),
        .cb_prgm_b(s_cb_s), .bit_in_CB(s_cb_b), .sb_prgm_b(s_sb_s), .bit_in_SB(s_sb_b),
        .done(s_done), .error(s_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Kind of the n-th accepted bit of a load: 0 CLB, 1 CB, 2 SB, 3 parity.
    function automatic int classify(input int n);
        int b[3];
        int t[3];
        int off, seg, slot, res;
        b[0] = CLB_B; b[1] = CB_B; b[2] = SB_B;
        t[0] = CLB_T; t[1] = CB_T; t[2] = SB_T;
        off = n;
        res = 3;
        for (int p = 0; p < 3; p++) begin
            seg = t[p] * (b[p] + PB);
            if (off >= 0 && off < seg) begin
                slot = off % (b[p] + PB);
                res  = (slot < b[p]) ? p : 3;
            end
            off -= seg;
        end
        return res;
    endfunction

    // ---------------- model of the default instance ----------------
    bit m_active, m_done, m_err, m_par;
    int m_n;
    bit e_clb_s, e_clb_b, e_cb_s, e_cb_b, e_sb_s, e_sb_b;
    bit cmp_en = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_active = 0; m_done = 0; m_err = 0; m_par = 0; m_n = 0;
            e_clb_s = 0; e_clb_b = 0; e_cb_s = 0; e_cb_b = 0; e_sb_s = 0; e_sb_b = 0;
        end else begin
            e_clb_s = 0; e_cb_s = 0; e_sb_s = 0;
            if (m_active) begin
                if (cfg_valid) begin
                    case (classify(m_n))
                        0: begin e_clb_s = 1; e_clb_b = cfg_bit; m_par ^= cfg_bit; end
                        1: begin e_cb_s  = 1; e_cb_b  = cfg_bit; m_par ^= cfg_bit; end
                        2: begin e_sb_s  = 1; e_sb_b  = cfg_bit; m_par ^= cfg_bit; end
                        default: begin
                            if (cfg_bit != m_par) m_err = 1;
                            m_par = 0;
                        end
                    endcase
                    m_n++;
                    if (m_n == TOTAL_ACC) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (start) begin
                m_active = 1; m_n = 0; m_done = 0; m_err = 0; m_par = 0;
            end
        end
    end

    logic [9:0] act_vec, exp_vec;
    assign act_vec = {cfg_ready, prgm_b, CLB_prgm_b, bit_in_CLB, cb_prgm_b, bit_in_CB,
                      sb_prgm_b, bit_in_SB, done, error};
    assign exp_vec = {m_active, !m_active, e_clb_s, e_clb_b, e_cb_s, e_cb_b,
                      e_sb_s, e_sb_b, m_done, m_err};

    // Per-cycle compare plus running strobe / prgm_b-low tallies.
    int tot_clb = 0, tot_cb = 0, tot_sb = 0, tot_lo = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cycle_outputs", {22'd0, act_vec}, {22'd0, exp_vec});
            if (CLB_prgm_b) tot_clb++;
            if (cb_prgm_b)  tot_cb++;
            if (sb_prgm_b)  tot_sb++;
            if (!prgm_b)    tot_lo++;
        end
    end

    // mode 0: valid held high; 1: valid toggles during CB; 2: start pulse
    // during SB; 3: random gaps plus one long stall.
    task automatic run_load(input int mode, input int abort_at, input int bad_idx);
        int  sent = 0, cyc = 0, kind;
        int  b_clb, b_cb, b_sb, b_lo;
        bit  v, b, tpar = 0, first_seen = 0, err_seen = 0, stalled = 0;
        b_clb = tot_clb; b_cb = tot_cb; b_sb = tot_sb; b_lo = tot_lo;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        while (sent < TOTAL_ACC && cyc < BUDGET) begin
            if (sent == 1 && !first_seen) begin
                check("first_strobe_is_clb", {29'd0, CLB_prgm_b, cb_prgm_b, sb_prgm_b}, 32'b100);
                first_seen = 1;
            end
            if (bad_idx >= 0 && sent == bad_idx + 1 && !err_seen) begin
                check("parity_error_set", {31'd0, error}, 32'd1);
                err_seen = 1;
            end
            if (abort_at >= 0 && sent == abort_at) begin
                cfg_valid = 0; start = 0; reset = 0;
                @(negedge clk);
                reset = 1;
                check("abort_reset_state", {22'd0, act_vec}, 32'h100);
                return;
            end
            if (mode == 3 && sent == 1500 && !stalled) begin
                cfg_valid = 0;
                repeat (60) @(negedge clk);
                cyc += 60;
                stalled = 1;
            end
            kind = classify(sent);
            v = 1;
            if (mode == 1 && kind == 1) v = cyc[0];
            if (mode == 3) v = ($urandom_range(3) != 0);
            if (kind == 3) b = tpar ^ (sent == bad_idx);
            else           b = 1'($urandom);
            start = (mode == 2 && sent == 2000);
            cfg_valid = v;
            cfg_bit   = b;
            if (v) begin
                if (kind == 3) tpar = 0;
                else           tpar ^= b;
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        cfg_valid = 0; start = 0;
        if (cyc >= BUDGET) begin
            checks++; errors++;
            $display("FAIL load_budget: %0d accepts sent, required %0d", sent, TOTAL_ACC);
        end
        check("done_after_last_accept", {31'd0, done}, 32'd1);
        check("prgm_b_released", {31'd0, prgm_b}, 32'd1);
        @(negedge clk);
        check("clb_strobe_count", tot_clb - b_clb, 32'd296);
        check("cb_strobe_count",  tot_cb - b_cb,   32'd192);
        check("sb_strobe_count",  tot_sb - b_sb,   32'd3072);
        if (mode == 0) check("prgm_b_low_cycles", tot_lo - b_lo, TOTAL_ACC);
        check("error_at_done", {31'd0, error}, (bad_idx >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_small();
        logic [9:0] seq;
        logic [2:0] stb;
        seq = S_SEQ;
        @(negedge clk); s_start = 1;
        @(negedge clk); s_start = 0;
        for (int i = 0; i <= S_N; i++) begin
            if (i > 0) begin
`ifdef CFG_PARITY_EN
                stb = (i - 1 < 4) ? 3'b010 : (i - 1 == 4 || i - 1 == 9) ? 3'b000 : 3'b001;
`else
                stb = (i - 1 < 4) ? 3'b010 : 3'b001;
`endif
                check("small_strobes", {29'd0, s_clb_s, s_cb_s, s_sb_s}, {29'd0, stb});
                if (stb == 3'b010) check("small_bit_cb", {31'd0, s_cb_b}, {31'd0, seq[i-1]});
                if (stb == 3'b001) check("small_bit_sb", {31'd0, s_sb_b}, {31'd0, seq[i-1]});
            end
            if (i < S_N) begin
                s_valid = 1;
                s_bit   = seq[i];
                @(negedge clk);
            end else begin
                s_valid = 0;
            end
        end
        check("small_done", {31'd0, s_done}, 32'd1);
        check("small_error", {31'd0, s_error}, 32'd0);
    endtask

    initial begin
        reset = 0; start = 0; cfg_bit = 0; cfg_valid = 0;
        s_start = 0; s_bit = 0; s_valid = 0;
        repeat (2) @(negedge clk);
        check("reset_state", {22'd0, act_vec}, 32'h100);
        check("reset_state_small", {22'd0, s_ready, s_prgm_b, s_clb_s, s_clb_b, s_cb_s,
                                    s_cb_b, s_sb_s, s_sb_b, s_done, s_error}, 32'h100);
        reset = 1;
        cmp_en = 1;

        run_load(0, -1, -1);        // full load, valid held high
        run_load(1, -1, -1);        // valid toggling in CB phase
        run_load(0, 1000, -1);      // reset after 1000 accepts
        run_load(0, -1, -1);        // fresh load after abort
        run_load(2, -1, -1);        // start ignored during SB
        run_load(3, -1, BAD_IDX);   // gaps, long stall, bad parity bit
        run_small();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 SHALL have parameter CLB_BITS, default 296, giving the configuration bits per CLB tile.
REQ-002 SHALL have parameter CLB_TILES, default 1, giving the number of CLB tiles on the chain.
REQ-003 SHALL have parameter CB_BITS, default 48, giving the bits per connection box.
REQ-004 SHALL have parameter CB_TILES, default 4, giving the number of connection boxes.
REQ-005 SHALL have parameter SB_BITS, default 768, giving the bits per switch box.
REQ-006 SHALL have parameter SB_TILES, default 4, giving the number of switch boxes.
REQ-007 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a full configuration load.
- cfg_bit  in  1  serial configuration bit from the host.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_ready  out  1  sequencer accepts cfg_bit this cycle.
- prgm_b  out  1  0 = programming in progress; 1 = idle or configured.
- CLB_prgm_b  out  1  CLB chain shift strobe.
- bit_in_CLB  out  1  CLB chain serial data.
- cb_prgm_b  out  1  CB chain shift strobe.
- bit_in_CB  out  1  CB chain serial data.
- sb_prgm_b  out  1  SB chain shift strobe.
- bit_in_SB  out  1  SB chain serial data.
- done  out  1  full load completed.
- error  out  1  sticky parity error (0 when CFG_PARITY_EN is undefined).

Function
REQ-008 SHALL implement the states IDLE, LOAD_CLB, LOAD_CB, LOAD_SB, PARITY and DONE.
REQ-009 SHALL transition IDLE or DONE -> LOAD_CLB on start=1; start SHALL be ignored in every other state.
REQ-010 SHALL assert cfg_ready=1 only in LOAD_CLB, LOAD_CB, LOAD_SB and PARITY; an accept is cfg_valid&&cfg_ready.
REQ-011 SHALL, on each accept in LOAD_x, drive x_prgm_b=1 and bit_in_x=cfg_bit registered for exactly the next cycle (latency 1); otherwise x_prgm_b=0 and bit_in_x holds its last value.
REQ-012 SHALL keep at most one of CLB_prgm_b, cb_prgm_b and sb_prgm_b high in any cycle.
REQ-013 SHALL stall on cfg_valid=0: no strobe and no counter advance, with no limit on the stall length.
REQ-014 SHALL keep a 10-bit bit counter and a 3-bit tile counter per load phase; the bit counter wraps to 0 after the accept that reaches x_BITS-1.
REQ-015 SHALL advance the tile counter at each bit-counter wrap; after tile x_TILES-1 the order SHALL be CLB -> CB -> SB -> DONE, with both counters cleared at each phase change.
REQ-016 SHALL skip any phase whose x_TILES is 0.
REQ-017 SHALL hold prgm_b=0 from the first cycle of LOAD_CLB until entry to DONE, and prgm_b=1 otherwise.
REQ-018 SHALL hold done=1 throughout DONE and clear it on the cycle a restart takes LOAD_CLB.
REQ-019 SHALL move the last strobe to its chain in the same cycle that done rises.
REQ-020 SHALL make a default-parameter load take exactly 3560 accepts.

Reset
REQ-021 SHALL, when reset=0 at a rising edge, enter IDLE, clear all counters, and drive prgm_b=1, all strobes=0, all bit_in_*=0, cfg_ready=0, done=0 and error=0.
REQ-022 SHALL abandon a load interrupted mid-operation by reset, and SHALL restart it only on a fresh start.

Configuration
REQ-023 SHALL, when macro CFG_PARITY_EN is defined, enter PARITY after each tile's last data bit.
REQ-024 SHALL, in PARITY, accept one bit with no chain strobe, compare it with the even parity of that tile's data bits, and set error=1 on mismatch; error is sticky until reset or start.
REQ-025 SHALL continue a load that has a parity error and still reach DONE.
REQ-026 SHALL make a default-parameter load take 3569 accepts when CFG_PARITY_EN is defined.
REQ-027 SHALL, when CFG_PARITY_EN is undefined, omit the PARITY state and tie error to 0.

Verification
REQ-028 Default parameters, start, cfg_valid held at 1, 3560 bits -> 296 CLB, then 192 CB, then 3072 SB strobes; done=1 on the cycle after the last accept; prgm_b low for 3560 cycles.
REQ-029 cfg_valid toggled 1,0,1,0 during LOAD_CB -> strobes only on cycles following cfg_valid=1; the CB strobe count is still 192.
REQ-030 reset=0 for one cycle after 1000 accepts, then start -> all outputs at reset values, and the next load again begins with CLB_prgm_b.
REQ-031 start pulsed during LOAD_SB -> no effect; the strobe sequence is unchanged.
REQ-032 With CFG_PARITY_EN defined, a wrong parity bit for CB tile 2 -> error=1 from the cycle after that accept; done=1 after 3569 accepts.
REQ-033 Parameters CLB_TILES=0, CB_TILES=1, CB_BITS=4, SB_TILES=1, SB_BITS=4, bits 1,0,1,1 then 0,1,1,0 -> bit_in_CB=1,0,1,1 then bit_in_SB=0,1,1,0, with no CLB strobe.
